// File: rtl/regdst_hazard_ctrl.sv
// regdst_hazard_ctrl: RegDst select, dest-register shadow pipe, EX forwarding selects and load-use stall FSM.
// Holds only control shadow state for the ID/EX, EX/MEM and MEM/WB registers.
module regdst_hazard_ctrl #(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rt,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             ex_regdst_sel,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_regwrite
);
    // cnt only needs to hold LOAD_STALL_CYCLES-2
    localparam int CW = LOAD_STALL_CYCLES > 2 ? $clog2(LOAD_STALL_CYCLES - 1) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [REG_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest;
    logic             ex_regwrite, ex_memread, mem_regwrite;
    logic             haz, bubble;

    assign haz = id_valid & ex_memread & ex_regwrite & (ex_dest != '0) &
                 ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
    assign bubble = flush | stall | !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE && haz && LOAD_STALL_CYCLES > 1) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(LOAD_STALL_CYCLES - 2);
        end else if (state == HOLD) begin
            state_nxt = cnt == '0 ? IDLE : HOLD;
            cnt_nxt   = cnt == '0 ? cnt : cnt - CW'(1);
        end
    end

    // a HOLD stall is unconditional: the bubble is already in EX
    always_comb stall = !flush & ((state == HOLD) | haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_regdst_sel <= 1'b0;
            mem_dest      <= '0;
            mem_regwrite  <= 1'b0;
            wb_dest       <= '0;
            wb_regwrite   <= 1'b0;
        end else begin
            ex_rs         <= bubble ? '0 : id_rs;
            ex_rt         <= bubble ? '0 : id_rt;
            ex_dest       <= bubble ? '0 : (id_regdst ? id_rd : id_rt);
            ex_regwrite   <= !bubble & id_regwrite;
            ex_memread    <= !bubble & id_memread;
            ex_regdst_sel <= !bubble & id_regdst;
            mem_dest      <= ex_dest;
            mem_regwrite  <= ex_regwrite;
            wb_dest       <= mem_dest;
            wb_regwrite   <= mem_regwrite;
        end
    end

    // MEM has the newer value, so it wins over WB; $0 never forwards
    always_comb begin
        fwd_a_sel = (mem_regwrite & (mem_dest != '0) & (mem_dest == ex_rs)) ? 2'b10 :
                    (wb_regwrite  & (wb_dest  != '0) & (wb_dest  == ex_rs)) ? 2'b01 : 2'b00;
        fwd_b_sel = (mem_regwrite & (mem_dest != '0) & (mem_dest == ex_rt)) ? 2'b10 :
                    (wb_regwrite  & (wb_dest  != '0) & (wb_dest  == ex_rt)) ? 2'b01 : 2'b00;
    end
endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// tb_regdst_hazard_ctrl: directed vectors for two instances (1 and 3 load-use stall cycles).
module tb_regdst_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_uses_rt = 1'b0, id_regdst = 1'b0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       sel1, stall1, wbw1, sel3, stall3, wbw3;
    logic [1:0] fa1, fb1, fa3, fb3;
    logic [4:0] wbd1, wbd3;
    int         n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    regdst_hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ex_regdst_sel(sel1), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall(stall1),
        .wb_dest(wbd1), .wb_regwrite(wbw1));

    regdst_hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ex_regdst_sel(sel3), .fwd_a_sel(fa3), .fwd_b_sel(fb3), .stall(stall3),
        .wb_dest(wbd3), .wb_regwrite(wbw3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic ut, input logic rdst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rt = ut; id_regdst = rdst; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic nop();
        id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_wbd", wbd1, 0);
        chk("rst_wbw", wbw1, 0);
        chk("rst_stall", stall3, 0);
        chk("rst_fwd", {fa1, fb1}, 0);
        chk("rst_sel", sel3, 0);
        rst_n = 1'b1;
        // RegDst: add $10 <- rt=$30 ignored
        id(1, 5'd1, 5'd30, 5'd10, 1, 1, 1, 0);
        tick();
        nop();
        half();
        chk("regdst_sel", sel1, 1);
        tick();
        half();
        chk("wb_before", wbw1, 0);
        tick();
        half();
        chk("wb_dest", wbd1, 10);
        chk("wb_regwrite", wbw3, 1);
        // async reset mid-stream
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_wbw", wbw1, 0);
        chk("async_sel", sel1, 0);
        tick();
        rst_n = 1'b1;
        id(1, 5'd1, 5'd2, 5'd7, 1, 1, 1, 0);
        tick();
        nop();
        half();
        chk("post_rst_sel", sel1, 1);
        repeat (3) tick();
        // forwarding priority
        id(1, 5'd1, 5'd2, 5'd8, 1, 1, 1, 0); tick();
        id(1, 5'd3, 5'd4, 5'd8, 1, 1, 1, 0); tick();
        id(1, 5'd8, 5'd5, 5'd11, 1, 1, 1, 0); tick();
        half();
        chk("fwd_mem_a", fa1, 2'b10);
        chk("fwd_mem_b", fb1, 2'b00);
        id(1, 5'd1, 5'd2, 5'd12, 1, 1, 1, 0); tick();
        id(1, 5'd1, 5'd2, 5'd13, 1, 1, 1, 0); tick();
        id(1, 5'd12, 5'd12, 5'd14, 1, 1, 1, 0); tick();
        half();
        chk("fwd_wb_a", fa1, 2'b01);
        chk("fwd_wb_b", fb3, 2'b01);
        nop();
        repeat (3) tick();
        // load-use: lw $9 then add rs=$9
        id(1, 5'd1, 5'd9, 5'd0, 0, 0, 1, 1); tick();
        id(1, 5'd9, 5'd2, 5'd14, 1, 1, 1, 0);
        half();
        chk("lu_stall1_c0", stall1, 1);
        chk("lu_stall3_c0", stall3, 1);
        tick(); half();
        chk("lu_stall1_c1", stall1, 0);
        chk("lu_bubble_fwd", fa1, 2'b00);
        chk("lu_stall3_c1", stall3, 1);
        tick(); half();
        chk("lu_fwd_wb", fa1, 2'b01);
        chk("lu_stall3_c2", stall3, 1);
        tick(); half();
        chk("lu_stall3_c3", stall3, 0);
        nop();
        repeat (4) tick();
        // $0 load never stalls or forwards
        id(1, 5'd1, 5'd0, 5'd0, 0, 0, 1, 1); tick();
        id(1, 5'd0, 5'd0, 5'd15, 1, 1, 1, 0);
        half();
        chk("z_stall1", stall1, 0);
        chk("z_stall3", stall3, 0);
        tick(); nop(); half();
        chk("z_fwd_a", fa1, 2'b00);
        chk("z_fwd_b", fb3, 2'b00);
        tick(); half();
        chk("z_wbw", wbw1, 1);
        chk("z_wbd", wbd1, 0);
        repeat (3) tick();
        // flush mid-HOLD aborts the remaining stall
        id(1, 5'd1, 5'd9, 5'd0, 0, 0, 1, 1); tick();
        id(1, 5'd9, 5'd2, 5'd14, 1, 1, 1, 0);
        half();
        chk("fl_stall_c0", stall3, 1);
        tick();
        flush = 1'b1;
        half();
        chk("fl_stall_same", stall3, 0);
        tick();
        flush = 1'b0;
        nop();
        half();
        chk("fl_idle", stall3, 0);
        repeat (2) tick();
        // flush squashes an otherwise valid capture
        id(1, 5'd1, 5'd2, 5'd16, 1, 1, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nop();
        half();
        chk("fl_bubble_sel", sel1, 0);
        tick(); tick(); half();
        chk("fl_bubble_wbw", wbw1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
